mac_operand_feeder: RTL and testbench
=====================================

Name: mac_operand_feeder

Overview:
- Upstream neighbour of pipe_mac; produces the 64-bit {weight, activation} AXIS stream that pipe_mac consumes.
- Holds one filter's FILTER_SIZE weights plus an optional bias in a local register file, loaded over a weight AXIS port.
- Pairs each incoming activation with the next stored weight and frames each window as follows:
  - optional bias beat first (tuser=1);
  - tlast on the final beat;
  - tid equals the window count.

Parameters:
- DW, 32, operand width (Q16.16), matches pipe_mac DW.
- IDW, 8, tid width.
- FILTER_SIZE, 25, weights per window (>=1).
- HAS_BIAS, 1, 1 = expect bias word after weights and emit bias beat per window.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- swaxis_tdata  in  DW  weight/bias load data
- swaxis_tvalid  in  1  weight load valid
- swaxis_tlast  in  1  marks final load word
- swaxis_tready  out  1  weight load ready
- saxis_tdata  in  DW  activation data
- saxis_tvalid  in  1  activation valid
- saxis_tready  out  1  activation ready
- maxis_tdata  out  2*DW  {weight[2*DW-1:DW], activation[DW-1:0]}
- maxis_tvalid  out  1  output valid
- maxis_tlast  out  1  last beat of window
- maxis_tuser  out  1  bias/initialise beat
- maxis_tid  out  IDW  window index
- maxis_tready  in  1  downstream ready
- weights_loaded  out  1  register file holds a complete filter
- err_wlen  out  1  sticky: load tlast misplaced

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rstn asynchronous, active-low.
  - On reset, all outputs are 0: maxis_* signals, weights_loaded, err_wlen, tid counter. State goes to LOAD and the register file contents are don't-care.
- States:
  - LOAD: swaxis_tready=1, saxis_tready=0.
    - Word k (0..FILTER_SIZE-1) is written to w[k]; if HAS_BIAS, word FILTER_SIZE is written to bias.
    - Load length is L = FILTER_SIZE + HAS_BIAS.
    - tlast on word L-1: set weights_loaded, go to BIAS (HAS_BIAS=1) or DATA (HAS_BIAS=0).
    - tlast before word L-1, or no tlast on word L-1: set err_wlen, reset word count, stay in LOAD, weights_loaded=0. The next load restarts at w[0].
  - BIAS: swaxis_tready=0, saxis_tready=0.
    - When the output register is free, emit {DW'0, bias}, tuser=1, tlast=0, tid=window count.
    - This makes pipe_mac's accumulator equal bias exactly (0*bias adds 0).
    - Then go to DATA.
  - DATA:
    - saxis_tready = (!maxis_tvalid | maxis_tready).
    - On each accepted activation a with index j, emit {w[j], a}, tuser=0, tlast=(j==FILTER_SIZE-1), tid=window count.
    - After j==FILTER_SIZE-1 is accepted:
      - window count increments, wrapping modulo 2^IDW;
      - j resets to 0;
      - if swaxis_tvalid=1 in that cycle, next state is LOAD (weight reload happens only at a window boundary), clearing weights_loaded;
      - otherwise next state is BIAS (HAS_BIAS=1) or DATA.
- Output register:
  - A single register slice drives all maxis_* signals.
  - The register is loaded when it is empty or maxis_tready=1.
  - maxis_tvalid drops only when maxis_tready=1 and no new beat is loaded.
  - Payload holds stable while tvalid=1 and tready=0.
- Latency: one cycle from the activation handshake to maxis_tvalid. Full throughput is one beat per cycle with maxis_tready tied high.
- Simultaneous events:
  - swaxis_tvalid mid-window is ignored (tready=0) until the window boundary.
  - Output drain and new load in the same cycle are allowed.
  - Neither the LOAD→BIAS/DATA nor the DATA→LOAD transition inserts a bubble beyond the state change.
- Reset mid-window: the partial window is discarded, maxis_tvalid=0 immediately, and weights must be reloaded.
- Arithmetic: none. This block is pure routing and counting.
- Counter widths: j and the load count use $clog2(FILTER_SIZE+1) bits.

Decomposition:
- Package mac_pkg:
  - DW, IDW, FILTER_SIZE defaults;
  - feeder_state_t enum {LOAD, BIAS, DATA};
  - macro-free helper constant LOAD_LEN.
- Share the package with pipe_mac.
- Sub-module axis_reg_slice, a parameterised width single-entry output register with the valid/ready rules above, reusable at pipe_mac's output.

Test Plan:
- Load 25×0x00010000 plus bias 0x00008000, stream activations 1..25 with tready=1:
  - 26 output beats;
  - beat0 = {0, 0x00008000} with tuser=1;
  - beat25 = {0x00010000, 0x19} with tlast=1;
  - all tid=0;
  - weights_loaded=1.
- Same stimulus with maxis_tready toggling 1/0 every cycle: beat order and payload identical, each beat held stable while stalled, saxis_tready low when the output is full and stalled.
- HAS_BIAS=0, FILTER_SIZE=3, weights {2,3,4}, activations {5,6,7}: output {2,5}, {3,6}, {4,7} with tlast on the third beat and tuser=0 throughout.
- Load with tlast on word 10 of 26: err_wlen=1 and sticky, weights_loaded=0, saxis_tready stays 0; a correct 26-word reload then streams normally.
- Run 257 windows back-to-back: tid sequence 0..255, 0. Assert swaxis_tvalid during window 3: reload accepted only after window 3's tlast beat.
- Assert rstn low mid-window after beat 10: maxis_tvalid=0 asynchronously, state returns to LOAD, tid resets to 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath (mac_operand_feeder, pipe_mac).
// Default operand and tid widths, the filter size and the feeder FSM state type.
package mac_pkg;

  localparam int DW_DEF          = 32;
  localparam int IDW_DEF         = 8;
  localparam int FILTER_SIZE_DEF = 25;
  localparam int HAS_BIAS_DEF    = 1;

  // Number of words in one filter load with the default parameters.
  localparam int LOAD_LEN = FILTER_SIZE_DEF + HAS_BIAS_DEF;

  typedef enum logic [1:0] {
    LOAD,
    BIAS,
    DATA
  } feeder_state_t;

  function automatic int load_len(input int filter_size, input int has_bias);
    return filter_size + ((has_bias != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXIS output register; one cycle latency, full throughput.
// Accepts whenever empty or draining; payload holds while out_vld && !out_rdy.
module axis_reg_slice #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_dat <= in_dat;
      end
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Pairs activations with stored filter weights into {weight, activation} beats for pipe_mac.
// One cycle from activation handshake to maxis_tvalid; saxis_tready follows the output register.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int IDW         = IDW_DEF,
  parameter int FILTER_SIZE = FILTER_SIZE_DEF,
  parameter int HAS_BIAS    = HAS_BIAS_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [DW-1:0]   swaxis_tdata,
  input  logic            swaxis_tvalid,
  input  logic            swaxis_tlast,
  output logic            swaxis_tready,
  input  logic [DW-1:0]   saxis_tdata,
  input  logic            saxis_tvalid,
  output logic            saxis_tready,
  output logic [2*DW-1:0] maxis_tdata,
  output logic            maxis_tvalid,
  output logic            maxis_tlast,
  output logic            maxis_tuser,
  output logic [IDW-1:0]  maxis_tid,
  input  logic            maxis_tready,
  output logic            weights_loaded,
  output logic            err_wlen
);

  localparam int CW  = $clog2(FILTER_SIZE + 1);
  localparam int LEN = load_len(FILTER_SIZE, HAS_BIAS);

  localparam logic [CW-1:0] LAST_LOAD = CW'(LEN - 1);
  localparam logic [CW-1:0] LAST_J    = CW'(FILTER_SIZE - 1);
  localparam logic [CW-1:0] N_WEIGHTS = CW'(FILTER_SIZE);

  // Where a completed load or a completed window leads.
  localparam feeder_state_t WIN_START = (HAS_BIAS != 0) ? BIAS : DATA;

  typedef struct packed {
    logic [2*DW-1:0] data;
    logic            last;
    logic            user;
    logic [IDW-1:0]  id;
  } beat_t;

  feeder_state_t  state;
  logic [CW-1:0]  ld_cnt;
  logic [CW-1:0]  j;
  logic [IDW-1:0] win_cnt;

  logic [DW-1:0]  w [FILTER_SIZE];
  logic [DW-1:0]  bias;

  logic  push_vld;
  logic  push_rdy;
  beat_t push_dat;
  beat_t out_dat;

  assign swaxis_tready = (state == LOAD);
  assign saxis_tready  = (state == DATA) && push_rdy;

  always_comb begin
    push_vld = 1'b0;
    push_dat = '0;
    case (state)
      BIAS: begin
        // Zero weight: the accumulator starts from exactly the bias value.
        push_vld      = 1'b1;
        push_dat.data = {{DW{1'b0}}, bias};
        push_dat.user = 1'b1;
        push_dat.id   = win_cnt;
      end
      DATA: begin
        push_vld      = saxis_tvalid;
        push_dat.data = {w[j], saxis_tdata};
        push_dat.last = (j == LAST_J);
        push_dat.id   = win_cnt;
      end
      default: begin
        push_vld = 1'b0;
      end
    endcase
  end

  // Register file has no reset; weights_loaded qualifies its contents.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && swaxis_tvalid) begin
      if (ld_cnt < N_WEIGHTS) begin
        w[ld_cnt] <= swaxis_tdata;
      end else begin
        bias <= swaxis_tdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= LOAD;
      ld_cnt         <= '0;
      j              <= '0;
      win_cnt        <= '0;
      weights_loaded <= 1'b0;
      err_wlen       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (swaxis_tvalid) begin
            if (swaxis_tlast && (ld_cnt == LAST_LOAD)) begin
              weights_loaded <= 1'b1;
              ld_cnt         <= '0;
              j              <= '0;
              state          <= WIN_START;
            end else if (swaxis_tlast || (ld_cnt == LAST_LOAD)) begin
              // Misframed load: discard it and restart at w[0].
              err_wlen       <= 1'b1;
              weights_loaded <= 1'b0;
              ld_cnt         <= '0;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        BIAS: begin
          if (push_rdy) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (saxis_tvalid && push_rdy) begin
            if (j == LAST_J) begin
              j       <= '0;
              win_cnt <= win_cnt + 1'b1;
              if (swaxis_tvalid) begin
                state          <= LOAD;
                weights_loaded <= 1'b0;
              end else begin
                state <= WIN_START;
              end
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  axis_reg_slice #(
    .W($bits(beat_t))
  ) u_out_slice (
    .clk    (clk),
    .rstn   (rstn),
    .in_vld (push_vld),
    .in_rdy (push_rdy),
    .in_dat (push_dat),
    .out_vld(maxis_tvalid),
    .out_rdy(maxis_tready),
    .out_dat(out_dat)
  );

  assign maxis_tdata = out_dat.data;
  assign maxis_tlast = out_dat.last;
  assign maxis_tuser = out_dat.user;
  assign maxis_tid   = out_dat.id;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: default 25+bias instance and a 3-tap no-bias instance.
module tb_mac_operand_feeder;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        u;
    logic [7:0]  id;
  } beat_t;

  logic clk = 1'b0;
  logic rstn;

  logic [31:0] swaxis_tdata, saxis_tdata;
  logic        swaxis_tvalid, swaxis_tlast, swaxis_tready;
  logic        saxis_tvalid, saxis_tready;
  logic [63:0] maxis_tdata;
  logic        maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tready;
  logic [7:0]  maxis_tid;
  logic        weights_loaded, err_wlen;

  logic [31:0] swaxis_tdata_3, saxis_tdata_3;
  logic        swaxis_tvalid_3, swaxis_tlast_3, swaxis_tready_3;
  logic        saxis_tvalid_3, saxis_tready_3;
  logic [63:0] maxis_tdata_3;
  logic        maxis_tvalid_3, maxis_tlast_3, maxis_tuser_3, maxis_tready_3;
  logic [7:0]  maxis_tid_3;
  logic        weights_loaded_3, err_wlen_3;

  beat_t q1[$];
  beat_t q3[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_operand_feeder #(.DW(32), .IDW(8), .FILTER_SIZE(25), .HAS_BIAS(1)) dut (
    .clk(clk), .rstn(rstn),
    .swaxis_tdata(swaxis_tdata), .swaxis_tvalid(swaxis_tvalid),
    .swaxis_tlast(swaxis_tlast), .swaxis_tready(swaxis_tready),
    .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid), .saxis_tready(saxis_tready),
    .maxis_tdata(maxis_tdata), .maxis_tvalid(maxis_tvalid), .maxis_tlast(maxis_tlast),
    .maxis_tuser(maxis_tuser), .maxis_tid(maxis_tid), .maxis_tready(maxis_tready),
    .weights_loaded(weights_loaded), .err_wlen(err_wlen)
  );

  mac_operand_feeder #(.DW(32), .IDW(8), .FILTER_SIZE(3), .HAS_BIAS(0)) dut3 (
    .clk(clk), .rstn(rstn),
    .swaxis_tdata(swaxis_tdata_3), .swaxis_tvalid(swaxis_tvalid_3),
    .swaxis_tlast(swaxis_tlast_3), .swaxis_tready(swaxis_tready_3),
    .saxis_tdata(saxis_tdata_3), .saxis_tvalid(saxis_tvalid_3), .saxis_tready(saxis_tready_3),
    .maxis_tdata(maxis_tdata_3), .maxis_tvalid(maxis_tvalid_3), .maxis_tlast(maxis_tlast_3),
    .maxis_tuser(maxis_tuser_3), .maxis_tid(maxis_tid_3), .maxis_tready(maxis_tready_3),
    .weights_loaded(weights_loaded_3), .err_wlen(err_wlen_3)
  );

  // Record every beat that will complete a handshake at the following rising edge.
  always @(negedge clk) begin
    if (maxis_tvalid && maxis_tready)
      q1.push_back(beat_t'({maxis_tdata, maxis_tlast, maxis_tuser, maxis_tid}));
    if (maxis_tvalid_3 && maxis_tready_3)
      q3.push_back(beat_t'({maxis_tdata_3, maxis_tlast_3, maxis_tuser_3, maxis_tid_3}));
  end

  // Expected beat j of a 25-tap window: weights 1.0, bias 0.5, activations base..base+24.
  function automatic beat_t exp_beat(input int j, input int base, input int tid);
    beat_t b;
    if (j == 0) b = {64'h0000_0000_0000_8000, 1'b0, 1'b1, 8'(tid)};
    else        b = {32'h0001_0000, 32'(base + j - 1), (j == 25), 1'b0, 8'(tid)};
    return b;
  endfunction

  task automatic apply_reset();
    rstn = 1'b0;
    swaxis_tvalid = 0; swaxis_tlast = 0; swaxis_tdata = 0;
    saxis_tvalid = 0; saxis_tdata = 0; maxis_tready = 1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    q1.delete();
    q3.delete();
  endtask

  task automatic load_filter(input int nw, input int last_at);
    int k = 0;
    int budget = 0;
    while (k < nw && budget < 200) begin
      swaxis_tvalid = 1'b1;
      swaxis_tdata  = (k < 25) ? 32'h0001_0000 : 32'h0000_8000;
      swaxis_tlast  = (k == last_at);
      @(negedge clk);
      if (swaxis_tready) k++;
      @(posedge clk); #1;
      budget++;
    end
    swaxis_tvalid = 1'b0;
    swaxis_tlast  = 1'b0;
    checks++;
    if (k < nw) begin
      errors++;
      $display("FAIL load_timeout words=%0d want=%0d", k, nw);
    end
  endtask

  task automatic drive_window(input int base, input bit stall, input bit reload, output int ncyc);
    int idx = 0;
    beat_t prev = '0;
    beat_t cur;
    bit prev_stall = 0;
    ncyc = 0;
    if (reload) begin
      swaxis_tvalid = 1'b1; swaxis_tdata = 32'h0001_0000; swaxis_tlast = 1'b0;
    end
    while (idx < 25 && ncyc < 500) begin
      saxis_tvalid = 1'b1;
      saxis_tdata  = 32'(base + idx);
      maxis_tready = stall ? ~maxis_tready : 1'b1;
      @(negedge clk);
      cur = {maxis_tdata, maxis_tlast, maxis_tuser, maxis_tid};
      if (stall) begin
        if (prev_stall) begin
          checks++;
          if ({maxis_tvalid, cur} !== {1'b1, prev}) begin
            errors++;
            $display("FAIL stall_hold got=%b/%h want=1/%h", maxis_tvalid, cur, prev);
          end
        end
        if (maxis_tvalid && !maxis_tready) begin
          checks++;
          if (saxis_tready !== 1'b0) begin
            errors++;
            $display("FAIL stall_saxis_tready got=%b want=0", saxis_tready);
          end
        end
        prev_stall = maxis_tvalid && !maxis_tready;
        prev = cur;
      end
      if (reload) begin
        checks++;
        if (swaxis_tready !== 1'b0) begin
          errors++;
          $display("FAIL midwindow_swaxis_tready got=%b want=0 idx=%0d", swaxis_tready, idx);
        end
      end
      if (saxis_tready) idx++;
      @(posedge clk); #1;
      ncyc++;
    end
    saxis_tvalid = 1'b0;
    maxis_tready = 1'b1;
    checks++;
    if (idx < 25) begin
      errors++;
      $display("FAIL window_timeout accepted=%0d want=25", idx);
    end
  endtask

  task automatic wait_beats(input int n);
    int b = 0;
    maxis_tready = 1'b1;
    while (q1.size() < n && b < n + 100) begin
      @(posedge clk); #1;
      b++;
    end
    checks++;
    if (q1.size() != n) begin
      errors++;
      $display("FAIL beat_count got=%0d want=%0d", q1.size(), n);
    end
  endtask

  task automatic check_window(input string name, input int base, input int tid);
    beat_t got, exp;
    for (int j = 0; j < 26; j++) begin
      got = q1.pop_front();
      exp = exp_beat(j, base, tid);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_beat%0d got=%h want=%h", name, j, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    swaxis_tvalid = 0; swaxis_tlast = 0; swaxis_tdata = 0;
    saxis_tvalid = 0; saxis_tdata = 0; maxis_tready = 1;
    swaxis_tvalid_3 = 0; swaxis_tlast_3 = 0; swaxis_tdata_3 = 0;
    saxis_tvalid_3 = 0; saxis_tdata_3 = 0; maxis_tready_3 = 1;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tid, maxis_tdata} !== 75'd0) begin
      errors++;
      $display("FAIL reset_maxis got=%b%b%b %h %h want=0", maxis_tvalid, maxis_tlast,
               maxis_tuser, maxis_tid, maxis_tdata);
    end
    checks++;
    if ({weights_loaded, err_wlen, swaxis_tready, saxis_tready} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_status got=%b%b%b%b want=0010", weights_loaded, err_wlen,
               swaxis_tready, saxis_tready);
    end
    checks++;
    if ({maxis_tvalid_3, weights_loaded_3, err_wlen_3, swaxis_tready_3} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_dut3 got=%b%b%b%b want=0001", maxis_tvalid_3, weights_loaded_3,
               err_wlen_3, swaxis_tready_3);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_basic();
    int nc;
    load_filter(26, 25);
    checks++;
    if ({weights_loaded, err_wlen} !== 2'b10) begin
      errors++;
      $display("FAIL basic_loaded got=%b%b want=10", weights_loaded, err_wlen);
    end
    drive_window(1, 0, 0, nc);
    checks++;
    if (nc != 26) begin
      errors++;
      $display("FAIL basic_throughput cycles=%0d want=26", nc);
    end
    wait_beats(26);
    check_window("basic", 1, 0);
  endtask

  task automatic test_stall();
    int nc;
    maxis_tready = 1'b1;
    drive_window(1, 1, 0, nc);
    wait_beats(26);
    check_window("stall", 1, 1);
  endtask

  task automatic test_nobias();
    int k = 0;
    int b = 0;
    beat_t got, exp;
    while (k < 3 && b < 50) begin
      swaxis_tvalid_3 = 1'b1; swaxis_tdata_3 = 32'(k + 2); swaxis_tlast_3 = (k == 2);
      @(negedge clk);
      if (swaxis_tready_3) k++;
      @(posedge clk); #1;
      b++;
    end
    swaxis_tvalid_3 = 1'b0; swaxis_tlast_3 = 1'b0;
    checks++;
    if (weights_loaded_3 !== 1'b1) begin
      errors++;
      $display("FAIL nobias_loaded got=%b want=1", weights_loaded_3);
    end
    k = 0;
    b = 0;
    while (k < 3 && b < 50) begin
      saxis_tvalid_3 = 1'b1; saxis_tdata_3 = 32'(k + 5);
      @(negedge clk);
      if (saxis_tready_3) k++;
      @(posedge clk); #1;
      b++;
    end
    saxis_tvalid_3 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (q3.size() != 3) begin
      errors++;
      $display("FAIL nobias_count got=%0d want=3", q3.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = q3.pop_front();
      exp = {32'(i + 2), 32'(i + 5), (i == 2), 1'b0, 8'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL nobias_beat%0d got=%h want=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_err_load();
    int nc;
    apply_reset();
    load_filter(11, 10);
    checks++;
    if ({err_wlen, weights_loaded} !== 2'b10) begin
      errors++;
      $display("FAIL err_after_short got=%b%b want=10", err_wlen, weights_loaded);
    end
    repeat (3) begin
      saxis_tvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (saxis_tready !== 1'b0) begin
        errors++;
        $display("FAIL err_saxis_tready got=%b want=0", saxis_tready);
      end
      @(posedge clk); #1;
    end
    saxis_tvalid = 1'b0;
    load_filter(26, 25);
    checks++;
    if ({err_wlen, weights_loaded} !== 2'b11) begin
      errors++;
      $display("FAIL err_after_reload got=%b%b want=11", err_wlen, weights_loaded);
    end
    drive_window(7, 0, 0, nc);
    wait_beats(26);
    check_window("reload", 7, 0);
  endtask

  task automatic test_back_to_back();
    int nc;
    int bad;
    beat_t got, exp;
    apply_reset();
    load_filter(26, 25);
    for (int w = 0; w < 257; w++) begin
      drive_window(1, 0, (w == 3), nc);
      if (w == 3) begin
        checks++;
        if ({swaxis_tready, weights_loaded} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_reload_entry got=%b%b want=10", swaxis_tready, weights_loaded);
        end
        load_filter(26, 25);
      end
    end
    wait_beats(257 * 26);
    for (int w = 0; w < 257; w++) begin
      bad = 0;
      for (int j = 0; j < 26; j++) begin
        got = q1.pop_front();
        exp = exp_beat(j, 1, w % 256);
        if (got !== exp) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL b2b_window%0d bad_beats=%0d want=0", w, bad);
      end
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    int b = 0;
    int nc;
    q1.delete();
    maxis_tready = 1'b1;
    while (q1.size() < 10 && b < 100) begin
      saxis_tvalid = 1'b1; saxis_tdata = 32'(100 + idx);
      @(negedge clk);
      if (saxis_tready) idx++;
      @(posedge clk); #1;
      b++;
    end
    checks++;
    if ({maxis_tvalid, maxis_tid} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL midrst_pre got=%b/%h want=1/01", maxis_tvalid, maxis_tid);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({maxis_tvalid, maxis_tid, weights_loaded, swaxis_tready, saxis_tready} !== 12'b0_00000000_010) begin
      errors++;
      $display("FAIL midrst_async got=%b %h %b%b%b want=0 00 010", maxis_tvalid, maxis_tid,
               weights_loaded, swaxis_tready, saxis_tready);
    end
    saxis_tvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    q1.delete();
    load_filter(26, 25);
    drive_window(1, 0, 0, nc);
    wait_beats(26);
    check_window("postrst", 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_nobias();
    test_err_load();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
